instr_fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, supported major opcodes,
// the NOP encoding and the {instr, pc} record carried by the fetch queue.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, decode and the EX redirect path.
// master = fetch unit view, slave = surrounding environment view.
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            id_ready;
  logic            id_illegal;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_illegal,
    input  imem_rdata, id_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_illegal,
    output imem_rdata, id_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with flush; pointers wrap, an occupancy
// counter one bit wider than the pointers tells full from empty.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

// File: rtl/instr_fetch_unit.sv
// PC generator + fixed-latency imem reader feeding decode through a credit-checked queue.
// Optional FETCH_OPCODE_CHECK_EN flags unsupported opcodes at the queue head.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] issue_pc_q, issue_pc_d;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;
  logic            req, push, pop;
  fetch_entry_t    head, push_entry;
  logic [PW:0]     count;
  logic            empty;

  always_comb begin
    // Conservative credit: a same-cycle pop is not counted, so pushes can never overflow.
    req        = ~rst & ~bus.redirect & ((CW'(count) + CW'(inflight_q)) < CW'(QDEPTH));
    push       = inflight_q & ~kill_q & ~bus.redirect;
    pop        = ~empty & bus.id_ready & ~bus.redirect;
    push_entry = '{instr: bus.imem_rdata, pc: issue_pc_q};
    pc_d       = pc_q;
    if (bus.redirect)  pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (req)      pc_d = pc_q + XLEN'(4);
    issue_pc_d = req ? pc_q : issue_pc_q;
    inflight_d = req;
    kill_d     = bus.redirect;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    issue_pc_q <= issue_pc_d;
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = ~empty;
  assign bus.id_instr  = head.instr;
  assign bus.id_pc     = head.pc;

`ifdef FETCH_OPCODE_CHECK_EN
  logic op_ok;
  always_comb begin
    case (head.instr[6:0])
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH: op_ok = 1'b1;
      default:                                          op_ok = 1'b0;
    endcase
  end
  assign bus.id_illegal = ~empty & ~op_ok;
`else
  assign bus.id_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit: per-cycle stimulus/expectation
// records plus hand-written reset and mid-run reset sequences.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

`ifdef FETCH_OPCODE_CHECK_EN
  localparam bit OPC_EN = 1'b1;
`else
  localparam bit OPC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus_a();
  instr_fetch_unit_if bus_b();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h80) return 32'h0000_006F;
    if (a == 32'h84) return 32'h0000_0033;
    return NOP_INSTR;
  endfunction

  always @(posedge clk) begin
    if (bus_a.imem_req) bus_a.imem_rdata <= mem_word(bus_a.imem_addr);
    if (bus_b.imem_req) bus_b.imem_rdata <= mem_word(bus_b.imem_addr);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rdy;
    bit          redir;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    bit          ill;
  } vec_t;

  function automatic vec_t mk(bit rdy, bit redir, logic [31:0] rpc, bit req,
                              logic [31:0] addr, bit valid, logic [31:0] pc, bit ill);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.req = req;
    v.addr = addr; v.valid = valid; v.pc = pc; v.ill = ill;
    return v;
  endfunction

  localparam int NV = 29;
  vec_t tbl [NV];
  logic [31:0] wrap_pc [3];

  initial begin
    int lat;
    bus_a.id_ready = 1'b0; bus_a.redirect = 1'b0; bus_a.redirect_pc = '0;
    bus_b.id_ready = 1'b1; bus_b.redirect = 1'b0; bus_b.redirect_pc = '0;
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0000_0000;

    // start-up streaming, then decode stall filling the queue
    tbl[0]  = mk(1, 0, 0,      1, 32'h000, 0, 0,      0);
    tbl[1]  = mk(1, 0, 0,      1, 32'h004, 0, 0,      0);
    tbl[2]  = mk(1, 0, 0,      1, 32'h008, 1, 32'h00, 0);
    tbl[3]  = mk(1, 0, 0,      1, 32'h00C, 1, 32'h04, 0);
    tbl[4]  = mk(0, 0, 0,      1, 32'h010, 1, 32'h08, 0);
    tbl[5]  = mk(0, 0, 0,      1, 32'h014, 1, 32'h08, 0);
    tbl[6]  = mk(0, 0, 0,      0, 32'h018, 1, 32'h08, 0);
    tbl[7]  = mk(0, 0, 0,      0, 32'h018, 1, 32'h08, 0);
    tbl[8]  = mk(0, 0, 0,      0, 32'h018, 1, 32'h08, 0);
    tbl[9]  = mk(1, 0, 0,      0, 32'h018, 1, 32'h08, 0);
    tbl[10] = mk(1, 0, 0,      1, 32'h018, 1, 32'h0C, 0);
    tbl[11] = mk(1, 0, 0,      1, 32'h01C, 1, 32'h10, 0);
    // three queued + one in flight, then redirect with ready high
    tbl[12] = mk(0, 0, 0,      1, 32'h020, 1, 32'h14, 0);
    tbl[13] = mk(1, 1, 32'h100, 0, 32'h024, 1, 32'h14, 0);
    tbl[14] = mk(1, 0, 0,      1, 32'h100, 0, 0,      0);
    tbl[15] = mk(1, 0, 0,      1, 32'h104, 0, 0,      0);
    tbl[16] = mk(1, 0, 0,      1, 32'h108, 1, 32'h100, 0);
    tbl[17] = mk(1, 0, 0,      1, 32'h10C, 1, 32'h104, 0);
    // back-to-back redirects, second one misaligned
    tbl[18] = mk(1, 1, 32'h200, 0, 32'h110, 1, 32'h108, 0);
    tbl[19] = mk(1, 1, 32'h303, 0, 32'h200, 0, 0,      0);
    tbl[20] = mk(1, 0, 0,      1, 32'h300, 0, 0,      0);
    tbl[21] = mk(1, 0, 0,      1, 32'h304, 0, 0,      0);
    tbl[22] = mk(1, 0, 0,      1, 32'h308, 1, 32'h300, 0);
    // jump into the JAL / R-type words for the opcode check
    tbl[23] = mk(1, 1, 32'h080, 0, 32'h30C, 1, 32'h304, 0);
    tbl[24] = mk(1, 0, 0,      1, 32'h080, 0, 0,      0);
    tbl[25] = mk(1, 0, 0,      1, 32'h084, 0, 0,      0);
    tbl[26] = mk(1, 0, 0,      1, 32'h088, 1, 32'h080, OPC_EN);
    tbl[27] = mk(1, 0, 0,      1, 32'h08C, 1, 32'h084, 0);
    tbl[28] = mk(1, 0, 0,      1, 32'h090, 1, 32'h088, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",      bus_a.imem_req,   0);
    chk("rst_valid",    bus_a.id_valid,   0);
    chk("rst_illegal",  bus_a.id_illegal, 0);
    chk("rst_req_b",    bus_b.imem_req,   0);
    chk("rst_valid_b",  bus_b.id_valid,   0);

    for (int k = 0; k < NV; k++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_a.id_ready    = tbl[k].rdy;
      bus_a.redirect    = tbl[k].redir;
      bus_a.redirect_pc = tbl[k].rpc;
      @(negedge clk);
      chk($sformatf("c%0d_req", k),     bus_a.imem_req,   tbl[k].req);
      chk($sformatf("c%0d_addr", k),    bus_a.imem_addr,  tbl[k].addr);
      chk($sformatf("c%0d_valid", k),   bus_a.id_valid,   tbl[k].valid);
      chk($sformatf("c%0d_illegal", k), bus_a.id_illegal, tbl[k].ill);
      if (tbl[k].valid) begin
        chk($sformatf("c%0d_pc", k),    bus_a.id_pc,    tbl[k].pc);
        chk($sformatf("c%0d_instr", k), bus_a.id_instr, mem_word(tbl[k].pc));
      end
      if (k == 0) chk("wrap_addr0", bus_b.imem_addr, 32'hFFFF_FFF8);
      if (k >= 2 && k <= 4) begin
        chk($sformatf("wrap_valid%0d", k), bus_b.id_valid, 1);
        chk($sformatf("wrap_pc%0d", k),    bus_b.id_pc,    wrap_pc[k-2]);
      end
    end

    // Reset while a fetch is in flight: the stale response must not surface.
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_a.redirect = 1'b0;
    @(negedge clk);
    chk("midrst_req", bus_a.imem_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid0", bus_a.id_valid, 0);
    chk("midrst_addr0",  bus_a.imem_addr, 32'h0);
    lat = 0;
    while (!bus_a.id_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("midrst_latency", lat, 2);
    chk("midrst_pc",      bus_a.id_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
